// File: rtl/key_pio_debounced.sv
// Avalon-MM input PIO with per-channel 2-FF sync, programmable debounce,
// selectable edge capture (W1C) and a masked level-sensitive irq.
module key_pio_debounced #(
  parameter int         WIDTH        = 4,
  parameter int         DB_W         = 20,
  parameter int         DB_DEFAULT   = 500000,
  parameter logic [1:0] EDGE_DEFAULT = 2'b01,
  parameter logic       IDLE_LEVEL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] db_update;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr_bits;
  logic [1:0]       edge_mode;
  logic [DB_W-1:0]  threshold;
  logic [DB_W-1:0]  thr_eff;
  logic [DB_W-1:0]  term_count;
  logic [DB_W-1:0]  db_cnt [WIDTH];
  logic             wr_en;
  logic             wr_mask;
  logic             wr_cap;
  logic             wr_mode;
  logic             wr_thr;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // Register write decode
  assign wr_en   = chipselect && !write_n;
  assign wr_mask = wr_en && (address == 3'd2);
  assign wr_cap  = wr_en && (address == 3'd3);
  assign wr_mode = wr_en && (address == 3'd4);
  assign wr_thr  = wr_en && (address == 3'd5);

  // A threshold of zero behaves as one so a change is still filtered by a cycle.
  assign thr_eff    = (threshold == '0) ? DB_W'(1) : threshold;
  assign term_count = thr_eff - DB_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= IDLE_VEC;
      sync_q    <= IDLE_VEC;
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
    end
  end

  // A threshold write restarts every pending transition, so it blocks the update too.
  always_comb begin
    db_update = '0;
    edge_set  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_update[i] = (sync_q[i] != db_q[i]) && (db_cnt[i] == term_count) && !wr_thr;
      edge_set[i]  = db_update[i] && (sync_q[i] ? edge_mode[1] : edge_mode[0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_thr || (sync_q[i] == db_q[i]) || db_update[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= IDLE_VEC;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (db_update[i]) begin
          db_q[i] <= sync_q[i];
        end
      end
    end
  end

  assign clr_bits = wr_cap ? writedata[WIDTH-1:0] : '0;

  // Set is applied after clear so an edge landing on a W1C cycle survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr_bits) | edge_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      edge_mode <= EDGE_DEFAULT;
      threshold <= DB_W'(DB_DEFAULT);
    end else begin
      if (wr_mask) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (wr_mode) begin
        edge_mode <= writedata[1:0];
      end
      if (wr_thr) begin
        threshold <= writedata[DB_W-1:0];
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      3'd0:    rd_next[WIDTH-1:0] = db_q;
      3'd1:    rd_next[WIDTH-1:0] = sync_q;
      3'd2:    rd_next[WIDTH-1:0] = irq_mask;
      3'd3:    rd_next[WIDTH-1:0] = edge_capture;
      3'd4:    rd_next[1:0]       = edge_mode;
      3'd5:    rd_next[DB_W-1:0]  = threshold;
      default: rd_next            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Scoreboard bench for key_pio_debounced: a run-length reference model
// predicts register reads and irq; a negedge monitor compares them.
module tb_key_pio_debounced;

  localparam int WIDTH      = 4;
  localparam int DB_W       = 20;
  localparam int DB_DEFAULT = 500000;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic [2:0]       address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [WIDTH-1:0] in_port    = '1;
  logic [31:0]      readdata;
  logic             irq;
  logic             rd_req     = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Reference model state
  logic [WIDTH-1:0] m_s1   = '1;
  logic [WIDTH-1:0] m_s2   = '1;
  logic [WIDTH-1:0] m_db   = '1;
  logic [WIDTH-1:0] m_mask = '0;
  logic [WIDTH-1:0] m_cap  = '0;
  logic [1:0]       m_mode = 2'b01;
  int               m_thr  = DB_DEFAULT;
  int               m_run [WIDTH];
  logic [WIDTH-1:0] m_set;
  logic [WIDTH-1:0] m_clr;
  int               m_teff;
  logic             m_wr;

  always #5 clk = ~clk;

  key_pio_debounced #(
    .WIDTH(WIDTH), .DB_W(DB_W), .DB_DEFAULT(DB_DEFAULT),
    .EDGE_DEFAULT(2'b01), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[WIDTH-1:0] = m_db;
      3'd1: r[WIDTH-1:0] = m_s2;
      3'd2: r[WIDTH-1:0] = m_mask;
      3'd3: r[WIDTH-1:0] = m_cap;
      3'd4: r[1:0] = m_mode;
      3'd5: r = 32'(m_thr);
      default: r = '0;
    endcase
    return r;
  endfunction

  // A channel's debounced value follows its synchronised value once the two
  // have disagreed for T consecutive clocks; a threshold write restarts all runs.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_db = '1; m_mask = '0; m_cap = '0;
      m_mode = 2'b01; m_thr = DB_DEFAULT;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      if (rd_req) exp_q.push_back('{address, model_read(address)});
      m_wr   = chipselect && !write_n;
      m_teff = (m_thr == 0) ? 1 : m_thr;
      m_set  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_wr && address == 3'd5) begin
          m_run[i] = 0;
        end else if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] >= m_teff) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
            if (m_db[i] ? m_mode[1] : m_mode[0]) m_set[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_clr = (m_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
      m_cap = (m_cap & ~m_clr) | m_set;
      if (m_wr) begin
        case (address)
          3'd2: m_mask = writedata[WIDTH-1:0];
          3'd4: m_mode = writedata[1:0];
          3'd5: m_thr  = int'(writedata[DB_W-1:0]);
          default: ;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (readdata !== e.val) begin
        fails++;
        $display("FAIL read_addr%0d: got 0x%0h expected 0x%0h at %0t", e.addr, readdata, e.val, $time);
      end
    end
    if (reset_n) begin
      tests++;
      if (irq !== |(m_cap & m_mask)) begin
        fails++;
        $display("FAIL irq: got %0b expected %0b at %0t", irq, |(m_cap & m_mask), $time);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a; rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0; chipselect = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Counts clock edges until irq is seen high, starting from edge count n0.
  task automatic edges_to_irq(input int n0, output int n);
    n = n0;
    while (n < 60) begin
      @(negedge clk);
      if (irq) break;
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_val("reset_readdata", readdata, 32'd0);
    check_val("reset_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int idx;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values
    for (int a = 0; a < 8; a++) bus_read(3'(a));

    // Single falling press with T=4
    bus_write(3'd5, 32'd4);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b0;
    edges_to_irq(0, n);
    check_val("press_latency", 32'(n), 32'd6);
    bus_read(3'd3);
    bus_read(3'd0);

    // Short glitch is filtered
    in_port[0] = 1'b1;
    idle(10);
    bus_write(3'd3, 32'hF);
    in_port[1] = 1'b0;
    idle(3);
    in_port[1] = 1'b1;
    idle(10);
    bus_read(3'd0);
    bus_read(3'd3);

    // Both edges, W1C between press and release
    bus_write(3'd4, 32'd3);
    bus_write(3'd2, 32'hF);
    in_port[2] = 1'b0;
    idle(10);
    bus_read(3'd3);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3);
    in_port[2] = 1'b1;
    idle(10);
    bus_read(3'd3);

    // W1C lands on the same edge as a new capture
    bus_write(3'd3, 32'hF);
    bus_write(3'd4, 32'd1);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b0;
    idle(5);
    bus_write(3'd3, 32'h1);
    check_val("set_wins_irq", 32'(irq), 32'd1);
    bus_read(3'd3);
    in_port[0] = 1'b1;
    idle(10);
    bus_write(3'd3, 32'hF);

    // Threshold rewrite mid-count restarts with the new T
    bus_write(3'd5, 32'd8);
    bus_write(3'd4, 32'd3);
    bus_write(3'd2, 32'hF);
    bus_write(3'd3, 32'hF);
    in_port[3] = 1'b0;
    idle(7);
    bus_write(3'd5, 32'd2);
    edges_to_irq(8, n);
    check_val("thr_rewrite_latency", 32'(n), 32'd10);
    bus_read(3'd0);

    // Reset in the middle of a debounce
    in_port[3] = 1'b1;
    bus_write(3'd5, 32'd8);
    idle(5);
    reset_pulse();
    bus_read(3'd0);
    bus_read(3'd3);
    bus_read(3'd5);
    idle(20);
    bus_read(3'd3);
    bus_read(3'd0);

    // Randomised traffic
    bus_write(3'd5, 32'd3);
    bus_write(3'd4, 32'd3);
    bus_write(3'd2, 32'hF);
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          idx = $urandom_range(0, WIDTH - 1);
          in_port[idx] = ~in_port[idx];
          idle($urandom_range(1, 8));
        end
        2, 3: begin
          in_port = WIDTH'($urandom);
          idle($urandom_range(1, 4));
        end
        4: bus_read(3'($urandom_range(0, 7)));
        5: bus_write(3'd5, 32'($urandom_range(0, 6)));
        6: bus_write(3'd4, 32'($urandom_range(0, 3)));
        7: bus_write(3'd2, $urandom);
        8: bus_write(3'd3, $urandom);
        default: begin
          bus_write(3'($urandom_range(6, 7)), $urandom);
          bus_read(3'($urandom_range(0, 7)));
        end
      endcase
    end
    for (int a = 0; a < 6; a++) bus_read(3'(a));
    idle(2);
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
